// File: rtl/fifo_burst_rd_pkg.sv
// fifo_burst_rd_pkg
//   Shared definitions for the FIFO burst read controller: FSM state
//   encodings (plain localparams for legacy users, plus the typed enum)
//   and the skid buffer depth.
package fifo_burst_rd_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_REQ   = S_REQ,
        ST_XFER  = S_XFER,
        ST_DRAIN = S_DRAIN
    } state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_skid.sv
// fifo_burst_skid
//   Two-entry skid buffer between the FIFO read port and the DMA beat port.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     push, din  : write one word (FIFO read data, one cycle after rd_en)
//     pop        : remove the head word
//     dout       : head word (held until popped)
//     count      : current occupancy, 0..2
module fifo_burst_skid
    import fifo_burst_rd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0_q;
    logic [DATA_W-1:0] ent1_q;
    logic [1:0]        cnt_q;
    logic              push_ok;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push_ok = push && ((cnt_q != 2'(SKID_DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= din;
                    else               ent1_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= din;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = ent0_q;
    assign count = cnt_q;

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// fifo_burst_rd_ctrl
//   Drains a FIFO into DMA bursts: a full burst when the water level reaches
//   BURST_LEN, or a partial burst of the current level after TIMEOUT idle
//   cycles with a non-zero level below BURST_LEN.
//   Ports:
//     rd_clk, rd_rst_n          : FIFO read clock, async active-low reset
//     enable                    : allows new bursts (checked only in IDLE)
//     fifo_rd_water_level/empty : FIFO read-side status
//     fifo_rd_en, fifo_rd_data  : FIFO read port (data one cycle after en)
//     dma_req, dma_len, dma_gnt : burst request / length / one-cycle grant
//     dma_data, dma_valid, dma_ready, dma_last : beat stream
//     busy                      : any state other than IDLE
//
//   state | meaning
//   IDLE  | waiting for full level or partial-level timeout
//   REQ   | dma_req high with latched length, waiting for dma_gnt
//   XFER  | issuing FIFO reads until len words have been read
//   DRAIN | all reads issued, emptying the skid buffer until the last beat
module fifo_burst_rd_ctrl
    import fifo_burst_rd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH_W   = 10,
    parameter int BURST_LEN = 32,
    parameter int TIMEOUT   = 1024,
    parameter int LEN_W     = 11
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic               enable,
    input  logic [DEPTH_W:0]   fifo_rd_water_level,
    input  logic               fifo_rd_empty,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    output logic               dma_req,
    output logic [LEN_W-1:0]   dma_len,
    input  logic               dma_gnt,
    output logic [DATA_W-1:0]  dma_data,
    output logic               dma_valid,
    input  logic               dma_ready,
    output logic               dma_last,
    output logic               busy
);

    localparam logic [DEPTH_W:0] BURST_LVL = (DEPTH_W+1)'(BURST_LEN);
    localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(BURST_LEN);
    localparam logic [15:0]      TMO_LOAD  = 16'(TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] popped_q;
    logic [15:0]      tmo_q;
    logic             rd_en_q;
    logic [1:0]       skid_cnt;
    logic [2:0]       occ;
    logic             lvl_full;
    logic             lvl_part;
    logic             tmo_hit;
    logic             pop;

    fifo_burst_skid #(.DATA_W(DATA_W)) u_skid (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .push  (rd_en_q),
        .din   (fifo_rd_data),
        .pop   (pop),
        .dout  (dma_data),
        .count (skid_cnt)
    );

    assign dma_valid = (skid_cnt != 2'd0);
    assign dma_last  = dma_valid && (popped_q == (len_q - LEN_W'(1)));
    assign dma_req   = (state_q == ST_REQ);
    assign dma_len   = len_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        lvl_full = (fifo_rd_water_level >= BURST_LVL);
        lvl_part = (fifo_rd_water_level != '0) && !lvl_full;
        tmo_hit  = (tmo_q == 16'd0);
        pop      = dma_valid && dma_ready;
        // Occupancy the skid will have once this cycle's in-flight word lands
        // and any pop retires; a new read is only safe if that leaves room.
        occ      = 3'(skid_cnt) + 3'(rd_en_q) - 3'(pop);
        fifo_rd_en = (state_q == ST_XFER) && (issued_q < len_q) &&
                     !fifo_rd_empty && (occ < 3'(SKID_DEPTH));

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable && (lvl_full || ((fifo_rd_water_level != '0) && tmo_hit)))
                          state_d = ST_REQ;
            ST_REQ:   if (dma_gnt) state_d = ST_XFER;
            ST_XFER:  if (issued_q == len_q) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && dma_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            tmo_q    <= TMO_LOAD;
            rd_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= fifo_rd_en;

            if ((state_q == ST_IDLE) && (state_d == ST_REQ))
                len_q <= lvl_full ? LEN_FULL : LEN_W'(fifo_rd_water_level);

            // Down-counter; it parks at zero so a late enable fires at once
            // instead of waiting for a wrap.
            if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && lvl_part) begin
                if (!tmo_hit) tmo_q <= tmo_q - 16'd1;
            end else begin
                tmo_q <= TMO_LOAD;
            end

            if ((state_q == ST_REQ) && dma_gnt) begin
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (fifo_rd_en) issued_q <= issued_q + LEN_W'(1);
                if (pop)        popped_q <= popped_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
module tb_fifo_burst_rd_ctrl;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        enable;
    logic [10:0] fifo_rd_water_level;
    logic        fifo_rd_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        dma_req;
    logic [10:0] dma_len;
    logic        dma_gnt;
    logic [31:0] dma_data;
    logic        dma_valid;
    logic        dma_ready;
    logic        dma_last;
    logic        busy;

    fifo_burst_rd_ctrl #(
        .DATA_W(32), .DEPTH_W(10), .BURST_LEN(32), .TIMEOUT(16), .LEN_W(11)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst_n            (rd_rst_n),
        .enable              (enable),
        .fifo_rd_water_level (fifo_rd_water_level),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .dma_req             (dma_req),
        .dma_len             (dma_len),
        .dma_gnt             (dma_gnt),
        .dma_data            (dma_data),
        .dma_valid           (dma_valid),
        .dma_ready           (dma_ready),
        .dma_last            (dma_last),
        .busy                (busy)
    );

    always #5 rd_clk = ~rd_clk;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          tests_run;
    int          tests_failed;
    int          lvl_force;
    int          underflow;
    int          last_span;
    logic [31:0] seq;

    logic        s_rd_en, s_req, s_valid, s_ready, s_last, s_busy;
    logic [10:0] s_len;
    logic [31:0] s_data;

    task automatic update_lvl();
        fifo_rd_water_level = (lvl_force >= 0) ? 11'(lvl_force) : 11'(fifo_q.size());
        fifo_rd_empty       = (fifo_q.size() == 0);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(seq);
            exp_q.push_back(seq);
            seq = seq + 32'd1;
        end
        update_lvl();
    endtask

    // One clock: sample outputs at the falling edge, then let the FIFO model
    // respond to the read enable seen at the rising edge.
    task automatic step();
        @(negedge rd_clk);
        s_rd_en = fifo_rd_en; s_req = dma_req;   s_len  = dma_len;
        s_valid = dma_valid;  s_ready = dma_ready; s_data = dma_data;
        s_last  = dma_last;   s_busy = busy;
        @(posedge rd_clk);
        #1;
        if (s_rd_en) begin
            if (fifo_q.size() == 0) underflow++;
            else fifo_rd_data = fifo_q.pop_front();
        end
        update_lvl();
    endtask

    task automatic flush();
        enable = 1'b0; dma_ready = 1'b0; dma_gnt = 1'b0;
        step(); step();
        fifo_q.delete(); exp_q.delete();
        lvl_force = -1; underflow = 0;
        update_lvl();
        step(); step();
    endtask

    task automatic wait_req(input int budget, output int n, output bit seen);
        n = 0; seen = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_req === 1'b1) begin seen = 1; break; end
            n++;
        end
    endtask

    // Grants the pending request and streams the burst against the scoreboard.
    task automatic run_burst(input int exp_len, input int gnt_dly, input int mode,
                             input int drop_at, input int refill_dly, input int refill_n,
                             input int abort_at);
        int beats, issued, steps, first_acc, last_acc, max_out, stall_err, last_err, empty_cnt;
        bit prev_stall, refilled;
        logic [31:0] p_data, exp_w;
        logic p_last;
        beats = 0; issued = 0; steps = 0; first_acc = -1; last_acc = -1; max_out = 0;
        stall_err = 0; last_err = 0; empty_cnt = 0; prev_stall = 0; refilled = 0;
        p_data = '0; p_last = 1'b0;
        tests_run++;
        if (s_len !== 11'(exp_len)) begin
            tests_failed++;
            $display("FAIL req_len: got %0d expected %0d", s_len, exp_len);
        end
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            tests_run++;
            if (s_req !== 1'b1 || s_len !== 11'(exp_len)) begin
                tests_failed++;
                $display("FAIL req_hold: req=%0b len=%0d expected req=1 len=%0d", s_req, s_len, exp_len);
            end
        end
        dma_gnt = 1'b1; step(); dma_gnt = 1'b0;
        while (beats < exp_len && steps < 400) begin
            dma_ready = (mode == 1) ? (steps % 2 == 0) : 1'b1;
            step();
            steps++;
            if (issued - beats > max_out) max_out = issued - beats;
            if (prev_stall && (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last))
                stall_err++;
            prev_stall = s_valid && !s_ready;
            p_data = s_data; p_last = s_last;
            if (s_rd_en) issued++;
            if (s_valid && s_ready) begin
                beats++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_unexpected: beat %0d data %0h with nothing expected", beats, s_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (s_data !== exp_w) begin
                        tests_failed++;
                        $display("FAIL beat_data: beat %0d got %0h expected %0h", beats, s_data, exp_w);
                    end
                end
                if (s_last !== (beats == exp_len)) last_err++;
                if (first_acc < 0) first_acc = steps;
                last_acc = steps;
                if (drop_at > 0 && beats == drop_at) enable = 1'b0;
            end
            if (refill_n > 0 && !refilled && fifo_q.size() == 0 && issued > 0) begin
                empty_cnt++;
                if (empty_cnt == refill_dly) begin
                    lvl_force = -1;
                    push_words(refill_n);
                    refilled = 1;
                end
            end
            if (abort_at > 0 && beats == abort_at) break;
        end
        if (abort_at > 0) return;
        enable = 1'b0; dma_ready = 1'b1;
        last_span = last_acc - first_acc;
        tests_run++;
        if (beats != exp_len) begin
            tests_failed++; $display("FAIL beat_count: got %0d expected %0d", beats, exp_len);
        end
        tests_run++;
        if (issued != exp_len) begin
            tests_failed++; $display("FAIL reads_issued: got %0d expected %0d", issued, exp_len);
        end
        tests_run++;
        if (last_err != 0) begin
            tests_failed++; $display("FAIL last_flag: %0d wrong beats, expected 0", last_err);
        end
        tests_run++;
        if (stall_err != 0) begin
            tests_failed++; $display("FAIL stall_hold: %0d unstable beats, expected 0", stall_err);
        end
        tests_run++;
        if (max_out > 2) begin
            tests_failed++; $display("FAIL skid_occupancy: got %0d expected <= 2", max_out);
        end
        tests_run++;
        if (underflow != 0) begin
            tests_failed++; $display("FAIL fifo_underflow: got %0d expected 0", underflow);
        end
        step();
        tests_run++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after: busy=%0b valid=%0b expected 0 0", s_busy, s_valid);
        end
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0; enable = 1'b1; dma_gnt = 1'b0; dma_ready = 1'b1;
        fifo_rd_data = '0; lvl_force = -1; underflow = 0; seq = 32'hC0DE_0000;
        push_words(40);
        #1;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if ({s_rd_en, s_req, s_len, s_valid, s_data, s_last, s_busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rd_en=%0b req=%0b len=%0d valid=%0b data=%0h last=%0b busy=%0b expected all 0",
                     s_rd_en, s_req, s_len, s_valid, s_data, s_last, s_busy);
        end
        tests_run++;
        if (fifo_q.size() != 40) begin
            tests_failed++; $display("FAIL reset_no_reads: level %0d expected 40", fifo_q.size());
        end
        flush();
        rd_rst_n = 1'b1;
        step(); step();
        tests_run++;
        if (s_busy !== 1'b0 || s_req !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_idle: busy=%0b req=%0b expected 0 0", s_busy, s_req);
        end
    endtask

    task automatic test_full_burst();
        int n; bit seen;
        flush();
        enable = 1'b1;
        push_words(40);
        wait_req(10, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL full_req: no request seen, expected one");
        end else begin
            run_burst(32, 2, 0, 0, 0, 0, 0);
            tests_run++;
            if (last_span != 31) begin
                tests_failed++; $display("FAIL full_throughput: span %0d cycles expected 31", last_span);
            end
        end
    endtask

    task automatic test_timeout();
        int n; bit seen;
        flush();
        enable = 1'b1;
        push_words(5);
        wait_req(40, n, seen);
        tests_run++;
        if (!seen || n != 16) begin
            tests_failed++; $display("FAIL timeout_cycle: seen=%0b after %0d cycles expected 16", seen, n);
        end
        if (seen) run_burst(5, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        int n; bit seen;
        flush();
        enable = 1'b1;
        push_words(40);
        wait_req(10, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL bp_req: no request seen, expected one");
        end else run_burst(32, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_underrun();
        int n; bit seen;
        flush();
        lvl_force = 40;
        push_words(10);
        enable = 1'b1;
        wait_req(10, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL underrun_req: no request seen, expected one");
        end else run_burst(32, 1, 0, 0, 20, 22, 0);
    endtask

    task automatic test_enable();
        int n, reqs; bit seen;
        flush();
        push_words(100);
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_req === 1'b1) reqs++;
        end
        tests_run++;
        if (reqs != 0) begin
            tests_failed++; $display("FAIL enable_off: req seen %0d cycles expected 0", reqs);
        end
        enable = 1'b1;
        wait_req(10, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL enable_req: no request seen, expected one");
        end else run_burst(32, 1, 0, 5, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int n, sz, reqs; bit seen;
        flush();
        enable = 1'b1;
        push_words(38);
        wait_req(10, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL rstmid_req: no request seen, expected one");
            return;
        end
        run_burst(32, 1, 0, 0, 0, 0, 7);
        rd_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({fifo_rd_en, dma_req, dma_len, dma_valid, dma_data, dma_last, busy} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: rd_en=%0b req=%0b len=%0d valid=%0b data=%0h last=%0b busy=%0b expected all 0",
                     fifo_rd_en, dma_req, dma_len, dma_valid, dma_data, dma_last, busy);
        end
        sz = fifo_q.size();
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (fifo_q.size() != sz || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_hold: level %0d busy %0b expected %0d 0", fifo_q.size(), s_busy, sz);
        end
        rd_rst_n = 1'b1;
        exp_q = fifo_q;
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_req === 1'b1) reqs++;
        end
        tests_run++;
        if (reqs != 0) begin
            tests_failed++; $display("FAIL rstmid_wait: req seen %0d cycles with level %0d expected 0", reqs, sz);
        end
        push_words(10);
        wait_req(5, n, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL rstmid_new_req: no request seen, expected one");
        end else run_burst(32, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; last_span = 0;
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_underrun();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_burst_rd_ctrl.md
FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: FIFO read-data and DMA data width in bits.
REQ-002 Parameter DEPTH_W, default 10: FIFO read-depth width; the water-level input is DEPTH_W+1 bits.
REQ-003 Parameter BURST_LEN, default 32: full-burst word count; legal range 2..2^DEPTH_W.
REQ-004 Parameter TIMEOUT, default 1024: idle cycles after which a partial burst is flushed; legal range 1..65535.
REQ-005 Parameter LEN_W, default 11: width of dma_len; SHALL satisfy 2^LEN_W > BURST_LEN.
REQ-006 rd_clk  in  1  single clock, equal to the FIFO read clock.
REQ-007 rd_rst_n  in  1  reset, asynchronous and active-low.
REQ-008 enable  in  1  permits new bursts to start; sampled only in IDLE.
REQ-009 fifo_rd_water_level  in  DEPTH_W+1  FIFO read-side fill level.
REQ-010 fifo_rd_empty  in  1  FIFO empty flag.
REQ-011 fifo_rd_en  out  1  FIFO read enable.
REQ-012 fifo_rd_data  in  DATA_W  FIFO read data, valid one cycle after fifo_rd_en.
REQ-013 dma_req  out  1  burst request.
REQ-014 dma_len  out  LEN_W  word count of the requested burst.
REQ-015 dma_gnt  in  1  one-cycle grant for the pending request.
REQ-016 dma_data  out  DATA_W  beat data.
REQ-017 dma_valid  out  1  beat valid.
REQ-018 dma_ready  in  1  beat accept.
REQ-019 dma_last  out  1  marks the final beat of the burst.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 State machine SHALL have states IDLE, REQ, XFER and DRAIN.
- IDLE -> REQ when enable=1 and level >= BURST_LEN; len = BURST_LEN.
- IDLE -> REQ when enable=1, level > 0 and the timeout counter = TIMEOUT-1; len = level.
REQ-022 Timeout counter SHALL increment in IDLE while 0 < level < BURST_LEN, and SHALL clear otherwise and on leaving IDLE.
REQ-023 In REQ, dma_req=1 and dma_len SHALL hold the latched len, stable until dma_gnt; dma_gnt -> XFER.
REQ-024 dma_gnt SHALL be ignored outside REQ.
REQ-025 In XFER, fifo_rd_en SHALL be 1 only when all of the following hold:
- reads issued < len;
- fifo_rd_empty = 0;
- (skid occupancy + in-flight read - pop this cycle) < 2.
REQ-026 A 2-entry skid buffer SHALL capture fifo_rd_data one cycle after each fifo_rd_en.
REQ-027 dma_valid SHALL equal skid-not-empty; dma_data SHALL be the head entry; a pop occurs on dma_valid & dma_ready.
REQ-028 dma_data and dma_last SHALL be held stable while dma_valid=1 and dma_ready=0.
REQ-029 dma_last SHALL be 1 on exactly beat len of the burst.
REQ-030 XFER -> DRAIN when reads issued = len; DRAIN -> IDLE on the pop of the last beat.
REQ-031 Exactly len beats SHALL be delivered per grant, with no loss or duplication under any dma_ready pattern.
REQ-032 Throughput SHALL be 1 beat/cycle sustained when dma_ready=1 and the FIFO is non-empty.
REQ-033 Deassertion of enable mid-burst SHALL NOT abort the burst.
REQ-034 fifo_rd_empty=1 during XFER SHALL stall reads without a state change.

Reset
REQ-035 While rd_rst_n=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, with counters and skid buffer cleared.
REQ-036 Reset assertion mid-burst SHALL abort immediately; the remaining FIFO words stay unread.

Structure
REQ-037 Package fifo_burst_rd_pkg SHALL hold the state enum and the skid depth constant (2).
REQ-038 Sub-module fifo_burst_skid (2-entry skid buffer) SHALL be instantiated once.

Verification
REQ-039 Full burst: level=40, BURST_LEN=32, dma_ready=1, gnt 2 cycles after req -> dma_len=32; 32 beats in 32 consecutive cycles; last on beat 32; returns to IDLE.
REQ-040 Timeout: level=5 held, TIMEOUT=16 -> req on cycle 16 with dma_len=5; 5 beats delivered in order.
REQ-041 Backpressure: dma_ready toggles 1010... -> 32 beats in FIFO order; data stable while stalled; fifo_rd_en never overruns the skid (occupancy <= 2).
REQ-042 Underrun: FIFO empties after 10 words of a 32-word burst, refilled 20 cycles later -> burst completes with 32 beats; no spurious dma_valid.
REQ-043 Reset at beat 7 of 32 -> all outputs 0 the next cycle; after release, a new request waits for level >= 32.
REQ-044 enable=0 with level=100 -> dma_req stays 0; enable drop during XFER -> current burst completes.
